wb_int_gateway: RTL
===================

WB_INT_GATEWAY -- requirements
Module: wb_int_gateway

Interface
REQ-001 SHALL have parameter INTERRUPTS, default 2: number of sources N, legal range 1..32; any other value SHALL be an elaboration error.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth per source, minimum 2.
REQ-003 SHALL have parameter CNT_W, default 2: width of the per-source edge counter.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have Wishbone slave ports, one per line:
- i_wb_stb, i_wb_cyc, i_wb_we: inputs, 1 bit each.
- i_wb_addr, i_wb_data: inputs, 32 bits each.
- i_wb_sel: input, 4 bits.
- i_wb_cti: input, 3 bits.
- o_wb_ack, o_wb_err: outputs, 1 bit each.
- o_wb_data: output, 32 bits.
REQ-007 SHALL have port i_irq_src, input, N bits: raw asynchronous interrupt lines.
REQ-008 SHALL have port o_int_request, output, N bits: gated requests to the PLIC.
REQ-009 SHALL have port i_int_cleared, input, N bits: per-source completion from the PLIC.

Function
REQ-010 Each source SHALL pass through a SYNC_STAGES-deep flip-flop synchronizer, then XOR with POLARITY[k], giving active signal a[k].
REQ-011 Register MODE at addr[7:0]=0x00 SHALL be RW: bit k=1 selects edge mode, 0 selects level mode.
REQ-012 Register POLARITY at 0x04 SHALL be RW: bit k=1 inverts source k.
REQ-013 Register STATUS at 0x08 SHALL be RO: bits[N-1:0] are the per-source "in service" flags (state WAIT).
REQ-014 Register bits at and above N SHALL read 0 and ignore writes; i_wb_sel SHALL be ignored (full-word access only).
REQ-015 Bus responses:
- o_wb_ack or o_wb_err SHALL assert exactly one cycle after i_wb_stb.
- No new response SHALL be issued in the cycle after a response.
- Read data SHALL be valid with ack; o_wb_data SHALL be 0 otherwise.
REQ-016 o_wb_err, instead of ack, SHALL flag any address other than 0x00/0x04/0x08 and any write to 0x08; register state SHALL be unchanged.
REQ-017 Edge detection: a rising edge of a[k] SHALL be a 0->1 transition of a[k] between consecutive cycles.
REQ-018 Each source SHALL run a three-state FSM, IDLE -> REQ -> WAIT.
REQ-019 IDLE SHALL go to REQ on a rising edge (edge mode) or on a[k]=1 (level mode).
REQ-020 REQ SHALL last exactly one cycle with o_int_request[k]=1, then go to WAIT; o_int_request[k] SHALL be 0 in every other state.
REQ-021 In WAIT with edge mode, each rising edge SHALL increment cnt[k], saturating at 2^CNT_W-1; further edges are dropped.
REQ-022 In WAIT with level mode, a[k] SHALL be ignored.
REQ-023 WAIT SHALL leave only on i_int_cleared[k]=1, as follows:
- edge mode, cnt>0: decrement cnt, go to REQ.
- level mode, a[k]=1: go to REQ.
- otherwise: go to IDLE.
REQ-024 A rising edge in the same cycle as i_int_cleared SHALL be counted before the decrement, so the net count is unchanged and the FSM goes to REQ.
REQ-025 i_int_cleared[k] asserted in IDLE or REQ SHALL be ignored.
REQ-026 Writing MODE SHALL clear cnt[k] for every bit whose value changes; FSM states SHALL be unaffected.
REQ-027 Writing POLARITY SHALL take effect after the synchronizer; a resulting a[k] 0->1 SHALL count as an edge.
REQ-028 Latency from a source transition at the synchronizer input to o_int_request SHALL be SYNC_STAGES+1 cycles.

Reset
REQ-029 On i_rst=1, immediately and asynchronously, the following SHALL go to 0:
- all FSMs to IDLE, cnt, MODE, POLARITY;
- synchronizer flops and edge history;
- o_int_request, o_wb_ack, o_wb_err, o_wb_data.
REQ-030 Reset mid-WAIT SHALL discard counted edges; after release, a source still active SHALL re-request only per REQ-019 (a level source requests again; an edge source needs a new edge).

Verification
REQ-031 Level mode, src0 held high from cycle 0 -> o_int_request[0] is a single pulse at cycle 3 (SYNC_STAGES=2), STATUS reads 0x1; pulse i_int_cleared[0] -> new pulse next cycle; drop src0 and clear -> STATUS reads 0x0.
REQ-032 MODE=0x1 (edge), 5 edges on src0 while in WAIT -> cnt saturates at 3; 4 clears yield 3 re-requests, then IDLE.
REQ-033 Edge coinciding with i_int_cleared in WAIT, cnt=1 -> cnt stays 1 and o_int_request pulses the next cycle.
REQ-034 POLARITY=0x2 with src1 low -> request on source 1; read of 0x0C -> err=1, ack=0; write to 0x08 -> err=1 and STATUS unchanged.
REQ-035 i_rst asserted asynchronously mid-cycle while source 1 is in WAIT with cnt=2 -> outputs 0 before the next edge; after release, no request without a new edge.

Source files
------------

// File: rtl/wb_int_gateway.sv
// Purpose : interrupt gateway between raw async IRQ lines and a PLIC, with a small
//           Wishbone register block (MODE 0x00, POLARITY 0x04, STATUS 0x08).
// Latency : source transition -> o_int_request is SYNC_STAGES+1 cycles; bus ack/err one cycle after strobe.
// Backpressure: none on interrupts (edges counted up to 2^CNT_W-1, rest dropped);
//           bus accepts at most one access every other cycle.
// Ports   : i_clk/i_rst            clock, async active-high reset
//           i_wb_*/o_wb_*          Wishbone slave (full-word access, sel/cti ignored)
//           i_irq_src              raw asynchronous interrupt lines
//           o_int_request          one-cycle request pulses to the PLIC
//           i_int_cleared          per-source completion from the PLIC
module wb_int_gateway #(
    parameter int INTERRUPTS  = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_we,
    input  logic [31:0]           i_wb_addr,
    input  logic [31:0]           i_wb_data,
    input  logic [3:0]            i_wb_sel,
    input  logic [2:0]            i_wb_cti,
    output logic                  o_wb_ack,
    output logic                  o_wb_err,
    output logic [31:0]           o_wb_data,
    input  logic [INTERRUPTS-1:0] i_irq_src,
    output logic [INTERRUPTS-1:0] o_int_request,
    input  logic [INTERRUPTS-1:0] i_int_cleared
);

    localparam int N = INTERRUPTS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    generate
        if (INTERRUPTS < 1 || INTERRUPTS > 32) begin : g_bad_interrupts
            $error("wb_int_gateway: INTERRUPTS must be in 1..32");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("wb_int_gateway: SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [N-1:0] mode_q;
    logic [N-1:0] polarity_q;
    logic [N-1:0] in_service;

    // ------------------------------------------------------------------
    // Synchronizer, polarity and edge history
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]                  active;
    logic [N-1:0]                  active_prev_q;
    logic [N-1:0]                  rise;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q        <= '0;
            active_prev_q <= '0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], i_irq_src};
            active_prev_q <= active;
        end
    end

    // Polarity is applied after the synchronizer, so a polarity write that
    // flips a[k] from 0 to 1 looks like an ordinary rising edge.
    assign active = sync_q[SYNC_STAGES-1] ^ polarity_q;
    assign rise   = active & ~active_prev_q;

    // ------------------------------------------------------------------
    // Wishbone decode
    // ------------------------------------------------------------------
    logic [7:0]  reg_addr;
    logic        bus_req;
    logic        addr_ok;
    logic        bus_bad;
    logic        mode_wr;
    logic        pol_wr;
    logic [31:0] rd_val;

    assign reg_addr = i_wb_addr[7:0];
    // The cycle right after a response never starts a new access.
    assign bus_req  = i_wb_stb & i_wb_cyc & ~(o_wb_ack | o_wb_err);
    assign addr_ok  = (reg_addr == 8'h00) || (reg_addr == 8'h04) || (reg_addr == 8'h08);
    assign bus_bad  = ~addr_ok | (i_wb_we & (reg_addr == 8'h08));
    assign mode_wr  = bus_req & i_wb_we & ~bus_bad & (reg_addr == 8'h00);
    assign pol_wr   = bus_req & i_wb_we & ~bus_bad & (reg_addr == 8'h04);

    always_comb begin
        rd_val = '0;
        case (reg_addr)
            8'h00:   rd_val[N-1:0] = mode_q;
            8'h04:   rd_val[N-1:0] = polarity_q;
            8'h08:   rd_val[N-1:0] = in_service;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wb_ack   <= 1'b0;
            o_wb_err   <= 1'b0;
            o_wb_data  <= '0;
            mode_q     <= '0;
            polarity_q <= '0;
        end else begin
            o_wb_ack  <= bus_req & ~bus_bad;
            o_wb_err  <= bus_req & bus_bad;
            o_wb_data <= (bus_req & ~bus_bad & ~i_wb_we) ? rd_val : 32'd0;
            if (mode_wr) begin
                mode_q <= i_wb_data[N-1:0];
            end
            if (pol_wr) begin
                polarity_q <= i_wb_data[N-1:0];
            end
        end
    end

    // sel/cti and upper address/data bits carry no meaning for this block.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{i_wb_sel, i_wb_cti, i_wb_addr[31:8], i_wb_data};

    // ------------------------------------------------------------------
    // Per-source gateway FSM
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N; k++) begin : g_src
        state_t           state_q;
        logic             req_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_acc;

        // Pending count including an edge arriving this cycle; an edge that
        // coincides with a clear is therefore counted before the decrement.
        assign cnt_acc = (mode_q[k] && rise[k] && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                state_q <= ST_IDLE;
                req_q   <= 1'b0;
                cnt_q   <= '0;
            end else begin
                req_q <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (mode_q[k] ? rise[k] : active[k]) begin
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                        end
                    end
                    ST_REQ: begin
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (i_int_cleared[k]) begin
                            if (mode_q[k]) begin
                                if (cnt_acc != '0) begin
                                    cnt_q   <= cnt_acc - 1'b1;
                                    state_q <= ST_REQ;
                                    req_q   <= 1'b1;
                                end else begin
                                    cnt_q   <= '0;
                                    state_q <= ST_IDLE;
                                end
                            end else if (active[k]) begin
                                state_q <= ST_REQ;
                                req_q   <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else if (mode_q[k]) begin
                            cnt_q <= cnt_acc;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
                // Changing a source's mode discards its stale edge count.
                if (mode_wr && (i_wb_data[k] != mode_q[k])) begin
                    cnt_q <= '0;
                end
            end
        end

        assign o_int_request[k] = req_q;
        assign in_service[k]    = (state_q == ST_WAIT);
    end

endmodule
